gecko_sched: RTL and testbench
==============================

Name: gecko_sched

Overview:
Sequencer for the gecko keystream PRNG.
- Captures a 121-bit key, holds gecko in reset, then shifts the key in serially and waits out gecko's diffusion phase.
- Afterwards XORs incoming ciphertext bytes with gecko keystream bytes, with valid/ready handshakes on both sides.
- Sits between the key register / boot loader and the byte-stream decryption path.
- Drives all gecko control pins: gecko_rst_n, gecko_clken, gecko_key, gecko_next.

Parameters:
CNT_W, 16, width of the byte counter (used only with GECKO_SCHED_CNT_EN).

Ports:
clk  in  1  system clock
rst  in  1  synchronous reset, active high
key_load  in  1  single-cycle strobe; capture key_in and (re)start sequencing
key_in  in  121  key, shifted LSB first
busy  out  1  high from key_load until the first keystream byte is available
key_zero  out  1  captured key is all zeros (stream passes through unmodified)
din  in  8  ciphertext byte
din_valid  in  1  din valid
din_ready  out  1  byte accepted when din_valid && din_ready
dout  out  8  plaintext byte
dout_valid  out  1  dout valid
dout_ready  in  1  downstream accepts dout
gecko_rst_n  out  1  to gecko rst_n (registered, glitch-free)
gecko_clken  out  1  to gecko clken
gecko_key  out  1  to gecko key
gecko_next  out  1  to gecko next
gecko_ready  in  1  from gecko ready
gecko_dout  in  8  from gecko dout
byte_cnt  out  CNT_W  bytes decrypted since key_load

Behaviour:
Reset values (rst=1):
- state IDLE, gecko_rst_n=0, gecko_clken=0, gecko_next=0.
- busy=0, key_zero=0, dout_valid=0, dout=0, byte_cnt=0.

States: IDLE, RST, LOAD, WARM, STREAM.
- IDLE: gecko held in reset, din_ready=0.
- key_load in any state, highest priority:
  - shift reg <= key_in; key_zero <= (key_in==0).
  - dout_valid <= 0 (pending byte discarded); byte_cnt <= 0.
  - busy <= 1; next state RST.
- RST: one cycle, gecko_rst_n=0, gecko_clken=0. Next state LOAD.
- LOAD: exactly 121 cycles, 7-bit counter 120→0.
  - gecko_rst_n=1, gecko_clken=1, gecko_key=shift[0]; shift right each cycle.
  - At count 0, go to WARM.
- WARM: gecko_clken=1, gecko_key=0. When gecko_ready=1: busy <= 0, go to STREAM.
- STREAM: gecko_clken=1.
  - din_ready = gecko_ready && (!dout_valid || dout_ready), combinational.
  - On transfer: dout <= din ^ gecko_dout; dout_valid <= 1; gecko_next=1 for that cycle only (combinational = transfer); byte_cnt += 1.
  - If dout_ready && dout_valid and there is no transfer: dout_valid <= 0.
  - A simultaneous drain and transfer keeps dout_valid=1 with the new byte.
- gecko_ready falls the cycle after gecko_next, so no extra guard is needed.
- Throughput: 1 byte per 9 cycles.
- Latency: key_load at cycle 0 → first din_ready possible at cycle 259 (1 RST + 121 LOAD + 128 DIFFUSE + 8 RUN, +1 registered ready).
- key_load during LOAD/WARM/STREAM aborts and restarts at RST. No byte from the old key appears after key_load.
- rst mid-operation returns to IDLE and holds gecko in reset.

Optional Feature:
GECKO_SCHED_CNT_EN:
- Defined: byte_cnt counts transfers, saturating at all-ones; cleared by rst and key_load.
- Undefined: byte_cnt tied to 0 and no counter logic.

Test Plan:
1. Key load timing:
   - rst; key_load with key_in=121'h1 at cycle 0.
   - gecko_rst_n=0 in cycle 1.
   - gecko_key=1 in cycle 2 only, then 0 for cycles 3..122.
   - busy falls and din_ready first rises at cycle 259.
2. Zero key passthrough: key_in=0 → key_zero=1; after warm-up, din=8'hA5 → dout=8'hA5.
3. Backpressure: dout_ready=0 after the first byte.
   - din_ready stays 0, dout holds its value, gecko_next never pulses.
   - Raising dout_ready releases the next transfer with no byte lost or duplicated.
4. Streaming: 16 bytes, dout_ready=1, nonzero key.
   - One transfer every 9 cycles.
   - dout == din ^ gecko_dout sampled at each transfer.
   - byte_cnt=16 (with CNT_W macro).
5. Rekey mid-stream: key_load during STREAM with dout_valid=1.
   - dout_valid clears next cycle; busy=1; byte_cnt=0.
   - din_ready returns 259 cycles later.
6. Reset mid-LOAD: rst at cycle 60 → IDLE, gecko_rst_n=0, all outputs at reset values.

Source files
------------

// File: rtl/gecko_sched_if.sv
// ---------------------------------------------------------------------------
// | Module   : gecko_sched_if                                               |
// | Purpose  : byte-stream handshake bundle for the gecko sequencer:        |
// |            ciphertext in (din) and plaintext out (dout), both with      |
// |            valid/ready.                                                 |
// | Revision : 1.0 - initial release                                        |
// ---------------------------------------------------------------------------
`default_nettype none
`timescale 1ns/1ps

interface gecko_sched_if;
    logic [7:0] din;
    logic       din_valid;
    logic       din_ready;
    logic [7:0] dout;
    logic       dout_valid;
    logic       dout_ready;

    // Upstream/downstream side: supplies ciphertext and consumes plaintext
    modport master (
        output din, din_valid, dout_ready,
        input  din_ready, dout, dout_valid
    );

    // Sequencer side
    modport slave (
        input  din, din_valid, dout_ready,
        output din_ready, dout, dout_valid
    );
endinterface

`default_nettype wire

// File: rtl/gecko_sched.sv
// ---------------------------------------------------------------------------
// | Module   : gecko_sched                                                  |
// | Purpose  : sequencer for the gecko keystream PRNG. Captures a 121-bit   |
// |            key, resets gecko, shifts the key in LSB first, waits out    |
// |            diffusion, then XORs ciphertext bytes with keystream bytes.  |
// | Options  : GECKO_SCHED_CNT_EN - enables the saturating byte counter;    |
// |            when undefined byte_cnt is tied to zero.                     |
// | Revision : 1.0 - initial release                                        |
// ---------------------------------------------------------------------------
`default_nettype none
`timescale 1ns/1ps

module gecko_sched #(
    parameter int CNT_W = 16
) (
    input  wire logic             clk,
    input  wire logic             rst,
    input  wire logic             key_load,
    input  wire logic [120:0]     key_in,
    output logic                  busy,
    output logic                  key_zero,
    gecko_sched_if.slave          strm,
    output logic                  gecko_rst_n,
    output logic                  gecko_clken,
    output logic                  gecko_key,
    output logic                  gecko_next,
    input  wire logic             gecko_ready,
    input  wire logic [7:0]       gecko_dout,
    output logic [CNT_W-1:0]      byte_cnt
);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_RST    = 3'd1,
        ST_LOAD   = 3'd2,
        ST_WARM   = 3'd3,
        ST_STREAM = 3'd4
    } state_t;

    localparam logic [6:0] c_LOAD_LAST = 7'd120;

    state_t         r_state;
    state_t         w_next;
    logic [120:0]   r_shift;
    logic [6:0]     r_load_cnt;
    logic           r_busy;
    logic           r_key_zero;
    logic           r_gecko_rst_n;
    logic [7:0]     r_dout;
    logic           r_dout_valid;
    logic           w_clken;
    logic           w_key;
    logic           w_din_ready;
    logic           w_xfer;
    logic           w_drain;
    logic [7:0]     w_ks;

    // A zero key means pass-through: keystream is masked off
    assign w_ks    = r_key_zero ? 8'h00 : gecko_dout;
    assign w_xfer  = strm.din_valid && w_din_ready;
    assign w_drain = r_dout_valid && strm.dout_ready;

    assign busy            = r_busy;
    assign key_zero        = r_key_zero;
    assign gecko_rst_n     = r_gecko_rst_n;
    assign gecko_clken     = w_clken;
    assign gecko_key       = w_key;
    assign gecko_next      = w_xfer;
    assign strm.din_ready  = w_din_ready;
    assign strm.dout       = r_dout;
    assign strm.dout_valid = r_dout_valid;

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state and gecko control decode; key_load overrides everything
    always_comb begin
        w_next      = r_state;
        w_clken     = 1'b0;
        w_key       = 1'b0;
        w_din_ready = 1'b0;
        case (r_state)
            ST_IDLE: begin
                w_next = ST_IDLE;
            end
            ST_RST: begin
                w_next = ST_LOAD;
            end
            ST_LOAD: begin
                w_clken = 1'b1;
                w_key   = r_shift[0];
                if (r_load_cnt == 7'd0) begin
                    w_next = ST_WARM;
                end
            end
            ST_WARM: begin
                w_clken = 1'b1;
                if (gecko_ready) begin
                    w_next = ST_STREAM;
                end
            end
            ST_STREAM: begin
                w_clken = 1'b1;
                // Refuse bytes on a rekey cycle so nothing from the old key is accepted
                w_din_ready = gecko_ready && (!r_dout_valid || strm.dout_ready) && !key_load;
            end
            default: begin
                w_next = ST_IDLE;
            end
        endcase
        if (key_load) begin
            w_next = ST_RST;
        end
    end

    // Key shift register, load counter, status flags and output byte register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_shift       <= '0;
            r_load_cnt    <= 7'd0;
            r_busy        <= 1'b0;
            r_key_zero    <= 1'b0;
            r_gecko_rst_n <= 1'b0;
            r_dout        <= 8'h00;
            r_dout_valid  <= 1'b0;
        end else begin
            // gecko reset is registered from the next state so the pin never glitches
            r_gecko_rst_n <= (w_next == ST_LOAD) || (w_next == ST_WARM) || (w_next == ST_STREAM);
            if (key_load) begin
                r_shift      <= key_in;
                r_key_zero   <= (key_in == '0);
                r_load_cnt   <= c_LOAD_LAST;
                r_busy       <= 1'b1;
                r_dout_valid <= 1'b0;
            end else begin
                if (r_state == ST_LOAD) begin
                    r_shift    <= r_shift >> 1;
                    r_load_cnt <= r_load_cnt - 7'd1;
                end
                if ((r_state == ST_WARM) && gecko_ready) begin
                    r_busy <= 1'b0;
                end
                if (w_xfer) begin
                    r_dout       <= strm.din ^ w_ks;
                    r_dout_valid <= 1'b1;
                end else if (w_drain) begin
                    r_dout_valid <= 1'b0;
                end
            end
        end
    end

`ifdef GECKO_SCHED_CNT_EN
    logic [CNT_W-1:0] r_byte_cnt;

    // Saturating count of accepted bytes since the last key_load
    always_ff @(posedge clk) begin
        if (rst) begin
            r_byte_cnt <= '0;
        end else if (key_load) begin
            r_byte_cnt <= '0;
        end else if (w_xfer && (r_byte_cnt != '1)) begin
            r_byte_cnt <= r_byte_cnt + CNT_W'(1);
        end
    end

    assign byte_cnt = r_byte_cnt;
`else
    assign byte_cnt = '0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_gecko_sched.sv
// ---------------------------------------------------------------------------
// | Module   : tb_gecko_sched                                               |
// | Purpose  : self-checking bench for gecko_sched with a behavioural gecko |
// |            model and a byte scoreboard. Honours GECKO_SCHED_CNT_EN.     |
// | Revision : 1.0 - initial release                                        |
// ---------------------------------------------------------------------------
`default_nettype none
`timescale 1ns/1ps

module tb_gecko_sched;
    localparam int CNT_W = 16;
`ifdef GECKO_SCHED_CNT_EN
    localparam bit c_CNT_ON = 1'b1;
`else
    localparam bit c_CNT_ON = 1'b0;
`endif

    logic             clk = 1'b0;
    logic             rst;
    logic             key_load;
    logic [120:0]     key_in;
    logic             busy;
    logic             key_zero;
    logic             gecko_rst_n;
    logic             gecko_clken;
    logic             gecko_key;
    logic             gecko_next;
    logic             gecko_ready;
    logic [7:0]       gecko_dout;
    logic [CNT_W-1:0] byte_cnt;

    gecko_sched_if sif();

    gecko_sched #(.CNT_W(CNT_W)) dut (
        .clk         (clk),
        .rst         (rst),
        .key_load    (key_load),
        .key_in      (key_in),
        .busy        (busy),
        .key_zero    (key_zero),
        .strm        (sif),
        .gecko_rst_n (gecko_rst_n),
        .gecko_clken (gecko_clken),
        .gecko_key   (gecko_key),
        .gecko_next  (gecko_next),
        .gecko_ready (gecko_ready),
        .gecko_dout  (gecko_dout),
        .byte_cnt    (byte_cnt)
    );

    always #5 clk = ~clk;

    // Behavioural gecko: 121 load + 128 diffuse + 8 run clocks before the first
    // byte, then 8 clocks of work after each next pulse. Zero key gives zero stream.
    int         g_cnt = 0;
    logic [7:0] g_dout = 8'h00;
    logic       tb_key_zero = 1'b0;

    always @(posedge clk) begin
        if (!gecko_rst_n) begin
            g_cnt <= 0;
        end else if (gecko_clken) begin
            if (gecko_next) begin
                g_cnt <= 248;
            end else if (g_cnt < 256) begin
                g_cnt <= g_cnt + 1;
                if (g_cnt == 255) g_dout <= tb_key_zero ? 8'h00 : 8'($urandom);
            end
        end
    end
    assign gecko_ready = (g_cnt == 256);
    assign gecko_dout  = g_dout;

    int n_chk = 0;
    int n_fail = 0;
    int cyc = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] exp_cnt(input int c);
        return c_CNT_ON ? 32'(c) : 32'd0;
    endfunction

    // Scoreboard: bytes accepted but not yet drained, in order
    logic [7:0] sbq[$];
    int         sb_cnt = 0;
    bit         sb_en = 1'b0;
    int         xfer_cyc[$];

    task automatic observe();
        logic xfer;
        logic drain;
        if (!sb_en) return;
        xfer  = sif.din_valid && sif.din_ready;
        drain = sif.dout_valid && sif.dout_ready;
        if (sbq.size() > 0) begin
            chk("sb_dout_valid", 32'(sif.dout_valid), 32'd1);
            chk("sb_dout", 32'(sif.dout), 32'(sbq[0]));
            if (!sif.dout_ready) chk("sb_stall_ready", 32'(sif.din_ready), 32'd0);
        end else begin
            chk("sb_dout_valid", 32'(sif.dout_valid), 32'd0);
        end
        chk("sb_byte_cnt", 32'(byte_cnt), exp_cnt(sb_cnt));
        chk("sb_next", 32'(gecko_next), 32'(xfer));
        if (rst || key_load) begin
            sbq.delete();
            sb_cnt = 0;
        end else begin
            if (drain && sbq.size() > 0) void'(sbq.pop_front());
            if (xfer) begin
                sbq.push_back(sif.din ^ gecko_dout);
                if (sb_cnt < 65535) sb_cnt++;
                xfer_cyc.push_back(cyc);
            end
        end
    endtask

    task automatic tick();
        #1;
        observe();
        @(negedge clk);
        cyc++;
    endtask

    task automatic do_key(input logic [120:0] k);
        key_in      = k;
        key_load    = 1'b1;
        tb_key_zero = (k == '0);
        tick();
        key_load    = 1'b0;
    endtask

    // Returns the cycle (key_load = cycle 0) at which din_ready is seen, or -1
    task automatic wait_ready(input int first, input int last, output int at);
        at = -1;
        for (int i = first; i <= last; i++) begin
            if (sif.din_ready) begin
                at = i;
                break;
            end
            tick();
        end
    endtask

    function automatic logic [120:0] rand_key();
        logic [127:0] t;
        t = {$urandom, $urandom, $urandom, $urandom};
        return t[120:0] | 121'd1;
    endfunction

    task automatic check_reset_vals(input string tag);
        chk({tag, "_rst_n"},   32'(gecko_rst_n),     32'd0);
        chk({tag, "_clken"},   32'(gecko_clken),     32'd0);
        chk({tag, "_next"},    32'(gecko_next),      32'd0);
        chk({tag, "_busy"},    32'(busy),            32'd0);
        chk({tag, "_keyzero"}, 32'(key_zero),        32'd0);
        chk({tag, "_dvalid"},  32'(sif.dout_valid),  32'd0);
        chk({tag, "_dout"},    32'(sif.dout),        32'd0);
        chk({tag, "_cnt"},     32'(byte_cnt),        32'd0);
        chk({tag, "_dready"},  32'(sif.din_ready),   32'd0);
    endtask

    typedef struct {
        int   c;
        logic rst_n;
        logic clken;
        logic key;
        logic busy;
        logic rdy;
    } tv_t;

    tv_t tv[8];

    initial begin
        int at;
        int n0;
        int guard;
        logic [7:0] held;

        // Expected gecko pins / status at chosen cycles after key_load of key 1
        tv[0] = '{1,   1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
        tv[1] = '{2,   1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
        tv[2] = '{3,   1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
        tv[3] = '{122, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
        tv[4] = '{123, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
        tv[5] = '{258, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
        tv[6] = '{259, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
        tv[7] = '{260, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1};

        rst            = 1'b1;
        key_load       = 1'b0;
        key_in         = '0;
        sif.din        = 8'h00;
        sif.din_valid  = 1'b0;
        sif.dout_ready = 1'b1;
        @(negedge clk);
        repeat (3) tick();
        check_reset_vals("reset");
        rst   = 1'b0;
        sb_en = 1'b1;
        tick();

        // Key load timing with key = 1
        do_key(121'd1);
        for (int c = 1; c <= 260; c++) begin
            foreach (tv[j]) begin
                if (tv[j].c == c) begin
                    chk("t1_rst_n", 32'(gecko_rst_n),   32'(tv[j].rst_n));
                    chk("t1_clken", 32'(gecko_clken),   32'(tv[j].clken));
                    chk("t1_key",   32'(gecko_key),     32'(tv[j].key));
                    chk("t1_busy",  32'(busy),          32'(tv[j].busy));
                    chk("t1_ready", 32'(sif.din_ready), 32'(tv[j].rdy));
                end
            end
            if (c <= 130) chk("t1_keybit", 32'(gecko_key), (c == 2) ? 32'd1 : 32'd0);
            tick();
        end

        // Zero key passes the stream through
        do_key('0);
        chk("t2_key_zero", 32'(key_zero), 32'd1);
        wait_ready(1, 400, at);
        chk("t2_latency", 32'(at), 32'd259);
        sif.din       = 8'hA5;
        sif.din_valid = 1'b1;
        tick();
        sif.din_valid = 1'b0;
        chk("t2_dout", 32'(sif.dout), 32'hA5);
        chk("t2_dvalid", 32'(sif.dout_valid), 32'd1);
        tick();

        // Streaming 16 bytes with a nonzero key
        do_key(rand_key());
        chk("t4_key_zero", 32'(key_zero), 32'd0);
        wait_ready(1, 400, at);
        chk("t4_latency", 32'(at), 32'd259);
        xfer_cyc.delete();
        sif.din_valid  = 1'b1;
        sif.dout_ready = 1'b1;
        guard = 0;
        while (xfer_cyc.size() < 16 && guard < 200) begin
            sif.din = 8'($urandom);
            tick();
            guard++;
        end
        chk("t4_count", 32'(xfer_cyc.size()), 32'd16);
        for (int i = 1; i < xfer_cyc.size(); i++)
            chk("t4_spacing", 32'(xfer_cyc[i] - xfer_cyc[i-1]), 32'd9);
        chk("t4_byte_cnt", 32'(byte_cnt), exp_cnt(16));

        // Backpressure: the 16th byte sits in dout while dout_ready is low
        sif.dout_ready = 1'b0;
        held = (sbq.size() > 0) ? sbq[0] : 8'h00;
        n0 = xfer_cyc.size();
        repeat (40) begin
            sif.din = 8'($urandom);
            tick();
        end
        chk("t3_no_xfer", 32'(xfer_cyc.size()), 32'(n0));
        chk("t3_hold", 32'(sif.dout), 32'(held));
        chk("t3_hold_valid", 32'(sif.dout_valid), 32'd1);
        sif.dout_ready = 1'b1;
        guard = 0;
        while (xfer_cyc.size() == n0 && guard < 20) begin
            tick();
            guard++;
        end
        chk("t3_release", 32'(xfer_cyc.size()), 32'(n0 + 1));

        // Rekey mid-stream while a byte is pending
        sif.dout_ready = 1'b0;
        n0 = xfer_cyc.size();
        guard = 0;
        while (!sif.dout_valid && guard < 20) begin
            tick();
            guard++;
        end
        chk("t5_pending", 32'(sif.dout_valid), 32'd1);
        do_key(rand_key());
        sif.din_valid  = 1'b0;
        sif.dout_ready = 1'b1;
        chk("t5_dvalid", 32'(sif.dout_valid), 32'd0);
        chk("t5_busy", 32'(busy), 32'd1);
        chk("t5_cnt", 32'(byte_cnt), 32'd0);
        wait_ready(1, 400, at);
        chk("t5_latency", 32'(at), 32'd259);

        // Random traffic against the scoreboard
        repeat (400) begin
            sif.din        = 8'($urandom);
            sif.din_valid  = 1'($urandom_range(0, 1));
            sif.dout_ready = ($urandom_range(0, 3) != 0);
            tick();
        end
        sif.din_valid  = 1'b0;
        sif.dout_ready = 1'b1;
        tick();
        tick();

        // Reset during LOAD
        do_key(rand_key());
        for (int c = 1; c < 60; c++) tick();
        chk("t6_in_load", 32'(gecko_clken), 32'd1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check_reset_vals("t6");
        repeat (3) begin
            tick();
            chk("t6_idle_rst_n", 32'(gecko_rst_n), 32'd0);
            chk("t6_idle_clken", 32'(gecko_clken), 32'd0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #1ms;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule

`default_nettype wire
